// File: rtl/grf_pkg.sv
// Shared constants for the multi-ported general register file (grf_mp).
package grf_pkg;

  // Default data width and register count.
  localparam int GRF_WIDTH    = 32;
  localparam int GRF_NREG     = 32;

  // Register index that is hardwired to zero and never becomes busy.
  localparam int GRF_ZERO_REG = 0;

endpackage : grf_pkg

// File: rtl/grf_mp_if.sv
// Bus interface of grf_mp: read ports, write ports, issue/scoreboard signals.
// The master drives addresses, write data and issue requests; the slave (the
// register file) returns read data, busy flags, iss_ready and busy_cnt.
//
// Issue handshake: iss_en is the valid and iss_ready the ready of a
// valid/ready pair. An issue is accepted only on a rising clk edge where both
// are 1; iss_ready depends combinationally on iss_addr and never on iss_en, so
// the master may hold iss_en high and wait. iss_en with iss_ready low is
// dropped for that cycle, and an accepted issue to register 0 has no effect.
interface grf_mp_if
  import grf_pkg::*;
#(
  parameter int WIDTH = GRF_WIDTH,
  parameter int NREG  = GRF_NREG,
  parameter int NRD   = 3,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 iss_ready;
  logic [AW:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, iss_ready, busy_cnt
  );

endinterface : grf_mp_if

// File: rtl/grf_mp_fwd.sv
// Per-read-port output stage of grf_mp: selects stored data or, when the
// optional GRF_MP_BYPASS_EN macro is defined, forwards same-cycle write data
// from the highest-index matching write port and masks the busy flag.
module grf_mp_fwd
  import grf_pkg::*;
#(
  parameter int WIDTH = GRF_WIDTH,
  parameter int AW    = 5,
  parameter int NWR   = 2
) (
  input  logic [AW-1:0]        i_rd_addr,
  input  logic [WIDTH-1:0]     i_stored,
  input  logic                 i_busy,
  input  logic [NWR-1:0]       i_wr_en,
  input  logic [NWR*AW-1:0]    i_wr_addr,
  input  logic [NWR*WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0]     o_rd_data,
  output logic                 o_rd_busy
);

`ifdef GRF_MP_BYPASS_EN
  // Forward write data: later write ports override earlier ones, so the
  // highest-index matching port wins, as it does for the stored write.
  always_comb begin
    o_rd_data = i_stored;
    o_rd_busy = i_busy;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr) &&
          (i_rd_addr != AW'(GRF_ZERO_REG))) begin
        o_rd_data = i_wr_data[j*WIDTH +: WIDTH];
        o_rd_busy = 1'b0;
      end
    end
  end
`else
  // Without bypass the stored value is returned; new data appears next cycle.
  logic w_unused;
  assign w_unused  = ^{i_wr_en, i_wr_addr, i_wr_data};
  assign o_rd_data = i_stored;
  assign o_rd_busy = i_busy;
`endif

endmodule : grf_mp_fwd

// File: rtl/grf_mp.sv
// grf_mp: multi-ported register file with an issue scoreboard.
// NRD combinational read ports, NWR write ports (highest index wins on an
// address clash), register 0 hardwired to zero, and a busy vector tracking
// registers with a pending write. Optional write-to-read bypass is compiled in
// when the macro GRF_MP_BYPASS_EN is defined.
module grf_mp
  import grf_pkg::*;
#(
  parameter int WIDTH = GRF_WIDTH,
  parameter int NREG  = GRF_NREG,
  parameter int NRD   = 3,
  parameter int NWR   = 2
) (
  input  logic     clk,
  input  logic     rst,
  grf_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  // Architectural state.
  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_busy;
  logic [AW:0]      r_busy_cnt;

  // Scoreboard next-state terms.
  logic [NREG-1:0]  w_clr_mask;
  logic [NREG-1:0]  w_cleared;
  logic [NREG-1:0]  w_busy_next;
  logic [AW:0]      w_clr_cnt;
  logic [AW:0]      w_cnt_next;
  logic             w_iss_ready;
  logic             w_iss_acc;

  // Per-port read results before packing onto the bus.
  logic [WIDTH-1:0] w_rd_data [NRD];
  logic [NRD-1:0]   w_rd_busy;

  // Register 0 is never busy, so it is always ready.
  assign w_iss_ready = (bus.iss_addr == AW'(GRF_ZERO_REG)) ? 1'b1
                                                            : !r_busy[bus.iss_addr];
  assign w_iss_acc   = bus.iss_en && w_iss_ready &&
                       (bus.iss_addr != AW'(GRF_ZERO_REG));

  // Scoreboard next state: writes clear busy, an accepted issue sets it last
  // so it wins over a writeback to the same register in the same cycle.
  always_comb begin
    w_clr_mask = '0;
    for (int j = 0; j < NWR; j++) begin
      if (bus.wr_en[j]) w_clr_mask[bus.wr_addr[j*AW +: AW]] = 1'b1;
    end
    w_busy_next = r_busy & ~w_clr_mask;
    if (w_iss_acc) w_busy_next[bus.iss_addr] = 1'b1;
    w_busy_next[GRF_ZERO_REG] = 1'b0;
  end

  // Counter delta: one per distinct busy register cleared. An accepted issue
  // targets a non-busy register, so it never coincides with a clear.
  always_comb begin
    w_cleared = r_busy & w_clr_mask;
    w_clr_cnt = '0;
    for (int k = 0; k < NREG; k++) begin
      w_clr_cnt = w_clr_cnt + {{AW{1'b0}}, w_cleared[k]};
    end
    w_cnt_next = r_busy_cnt + {{AW{1'b0}}, w_iss_acc} - w_clr_cnt;
  end

  // Register array: ascending port order lets the highest-index port win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != AW'(GRF_ZERO_REG))) begin
          r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Busy vector and its population counter advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  // One forwarding stage per read port.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_stored;

    assign w_addr   = bus.rd_addr[i*AW +: AW];
    assign w_stored = (w_addr == AW'(GRF_ZERO_REG)) ? '0 : r_regs[w_addr];

    grf_mp_fwd #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .NWR   (NWR)
    ) u_fwd (
      .i_rd_addr (w_addr),
      .i_stored  (w_stored),
      .i_busy    (r_busy[w_addr]),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_rd_data (w_rd_data[i]),
      .o_rd_busy (w_rd_busy[i])
    );
  end

  // Pack per-port read data onto the bus.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NRD; i++) bus.rd_data[i*WIDTH +: WIDTH] = w_rd_data[i];
  end

  assign bus.rd_busy   = w_rd_busy;
  assign bus.iss_ready = w_iss_ready;
  assign bus.busy_cnt  = r_busy_cnt;

endmodule : grf_mp

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file.
module tb_grf_mp;
  import grf_pkg::*;

  localparam int W    = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = $clog2(NREG);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grf_mp_if #(.WIDTH(W), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  grf_mp #(.WIDTH(W), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus state ----------------
  logic [AW-1:0] rd_a [NRD];
  logic          we   [NWR];
  logic [AW-1:0] wa   [NWR];
  logic [W-1:0]  wd   [NWR];
  logic          ie;
  logic [AW-1:0] ia;

  // ---------------- reference model ----------------
  logic [W-1:0]  m_regs [NREG];
  bit            m_busy [NREG];

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] m_rd(int i);
    logic [W-1:0] v;
    if (rd_a[i] == 0) return '0;
    v = m_regs[rd_a[i]];
`ifdef GRF_MP_BYPASS_EN
    for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == rd_a[i]) v = wd[j];
`endif
    return v;
  endfunction

  function automatic logic m_rd_busy(int i);
    logic b;
    if (rd_a[i] == 0) return 1'b0;
    b = m_busy[rd_a[i]];
`ifdef GRF_MP_BYPASS_EN
    for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == rd_a[i]) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic m_ready();
    return (ia == 0) || !m_busy[ia];
  endfunction

  function automatic logic [AW:0] m_cnt();
    int s = 0;
    for (int k = 0; k < NREG; k++) s += int'(m_busy[k]);
    return (AW+1)'(s);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_step();
    logic acc;
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        m_regs[k] = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      acc = ie && (ia != 0) && !m_busy[ia];
      for (int j = 0; j < NWR; j++) if (we[j] && wa[j] != 0) m_regs[wa[j]] = wd[j];
      for (int j = 0; j < NWR; j++) if (we[j]) m_busy[wa[j]] = 1'b0;
      if (acc) m_busy[ia] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    logic [NRD*AW-1:0] ra;
    logic [NWR-1:0]    en;
    logic [NWR*AW-1:0] a;
    logic [NWR*W-1:0]  d;
    for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = rd_a[i];
    for (int j = 0; j < NWR; j++) begin
      en[j]         = we[j];
      a[j*AW +: AW] = wa[j];
      d[j*W +: W]   = wd[j];
    end
    bus.rd_addr  = ra;
    bus.wr_en    = en;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.iss_en   = ie;
    bus.iss_addr = ia;
  endtask

  task automatic idle();
    for (int i = 0; i < NRD; i++) rd_a[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      we[j] = 1'b0;
      wa[j] = '0;
      wd[j] = '0;
    end
    ie = 1'b0;
    ia = '0;
    apply();
  endtask

  // Inputs change after the falling edge; the model follows each rising edge.
  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); rd_a[0] = 5; ia = 5; apply(); #1;
    n_vec++; if (bus.rd_data[W-1:0] !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", bus.rd_data[W-1:0]); end
    n_vec++; if (bus.busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.busy_cnt); end
    n_vec++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", bus.iss_ready); end
    n_vec++; if (bus.rd_busy !== 3'b000) begin n_err++; $display("FAIL reset_rdbusy: got %0b want 0", bus.rd_busy); end
    // write r5 and issue r5 together, then reset with a competing write+issue
    we[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF; ie = 1; ia = 5; apply(); tick();
    idle(); rd_a[0] = 5; apply(); #1;
    n_vec++; if (bus.rd_data[W-1:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL r5_written: got %0h want deadbeef", bus.rd_data[W-1:0]); end
    n_vec++; if (bus.busy_cnt !== 6'd1) begin n_err++; $display("FAIL r5_busy_cnt: got %0d want 1", bus.busy_cnt); end
    rst = 1; we[1] = 1; wa[1] = 5; wd[1] = 32'h1234; ie = 1; ia = 6; apply(); tick();
    rst = 0; idle(); rd_a[0] = 5; ia = 5; apply(); #1;
    n_vec++; if (bus.rd_data[W-1:0] !== 32'h0) begin n_err++; $display("FAIL r5_after_rst: got %0h want 0", bus.rd_data[W-1:0]); end
    n_vec++; if (bus.busy_cnt !== 6'd0) begin n_err++; $display("FAIL cnt_after_rst: got %0d want 0", bus.busy_cnt); end
    n_vec++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_rst: got %0b want 1", bus.iss_ready); end
    n_vec++; if (bus.rd_busy !== 3'b000) begin n_err++; $display("FAIL rdbusy_after_rst: got %0b want 0", bus.rd_busy); end
  endtask

  task automatic test_dual_write();
    idle(); we[0] = 1; wa[0] = 7; wd[0] = 32'h1111; we[1] = 1; wa[1] = 7; wd[1] = 32'h2222;
    apply(); tick();
    idle(); rd_a[1] = 7; apply(); #1;
    n_vec++; if (bus.rd_data[W +: W] !== 32'h2222) begin n_err++; $display("FAIL dual_write: got %0h want 2222", bus.rd_data[W +: W]); end
  endtask

  task automatic test_scoreboard();
    idle(); ie = 1; ia = 3; apply(); #1;
    n_vec++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready_before: got %0b want 1", bus.iss_ready); end
    tick();
    idle(); rd_a[1] = 3; ia = 3; apply(); #1;
    n_vec++; if (bus.rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL sb_rdbusy: got %0b want 1", bus.rd_busy[1]); end
    n_vec++; if (bus.iss_ready !== 1'b0) begin n_err++; $display("FAIL sb_ready: got %0b want 0", bus.iss_ready); end
    n_vec++; if (bus.busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt: got %0d want 1", bus.busy_cnt); end
    we[0] = 1; wa[0] = 3; wd[0] = 32'h55; apply(); #1;
`ifdef GRF_MP_BYPASS_EN
    n_vec++; if (bus.rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL sb_rdbusy_wb: got %0b want 0", bus.rd_busy[1]); end
`else
    n_vec++; if (bus.rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL sb_rdbusy_wb: got %0b want 1", bus.rd_busy[1]); end
`endif
    tick();
    idle(); rd_a[1] = 3; ia = 3; apply(); #1;
    n_vec++; if (bus.rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL sb_cleared: got %0b want 0", bus.rd_busy[1]); end
    n_vec++; if (bus.busy_cnt !== 6'd0) begin n_err++; $display("FAIL sb_cnt_cleared: got %0d want 0", bus.busy_cnt); end
    n_vec++; if (bus.rd_data[W +: W] !== 32'h55) begin n_err++; $display("FAIL sb_data: got %0h want 55", bus.rd_data[W +: W]); end
  endtask

  task automatic test_issue_writeback();
    idle(); ie = 1; ia = 4; apply(); tick();
    idle(); ie = 1; ia = 4; we[1] = 1; wa[1] = 4; wd[1] = 32'h44; apply(); #1;
    n_vec++; if (bus.iss_ready !== 1'b0) begin n_err++; $display("FAIL iwb_reject: got %0b want 0", bus.iss_ready); end
    tick();
    idle(); rd_a[2] = 4; apply(); #1;
    n_vec++; if (bus.rd_busy[2] !== 1'b0) begin n_err++; $display("FAIL iwb_notbusy: got %0b want 0", bus.rd_busy[2]); end
    n_vec++; if (bus.busy_cnt !== 6'd0) begin n_err++; $display("FAIL iwb_cnt0: got %0d want 0", bus.busy_cnt); end
    ie = 1; ia = 4; we[0] = 1; wa[0] = 4; wd[0] = 32'h45; apply(); #1;
    n_vec++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL iwb_accept: got %0b want 1", bus.iss_ready); end
    tick();
    idle(); rd_a[2] = 4; ia = 4; apply(); #1;
    n_vec++; if (bus.rd_busy[2] !== 1'b1) begin n_err++; $display("FAIL iwb_busy: got %0b want 1", bus.rd_busy[2]); end
    n_vec++; if (bus.busy_cnt !== 6'd1) begin n_err++; $display("FAIL iwb_cnt1: got %0d want 1", bus.busy_cnt); end
    n_vec++; if (bus.rd_data[2*W +: W] !== 32'h45) begin n_err++; $display("FAIL iwb_data: got %0h want 45", bus.rd_data[2*W +: W]); end
    idle(); we[0] = 1; wa[0] = 4; wd[0] = 32'h46; apply(); tick();
  endtask

  task automatic test_r0();
    idle(); ie = 1; ia = 6; apply(); tick();
    idle(); we[0] = 1; wa[0] = 0; wd[0] = 32'hFFFFFFFF; ie = 1; ia = 0; apply(); #1;
    n_vec++; if (bus.iss_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %0b want 1", bus.iss_ready); end
    n_vec++; if (bus.rd_data[W-1:0] !== 32'h0) begin n_err++; $display("FAIL r0_same_cycle: got %0h want 0", bus.rd_data[W-1:0]); end
    tick();
    idle(); apply(); #1;
    n_vec++; if (bus.rd_data !== 96'h0) begin n_err++; $display("FAIL r0_read: got %0h want 0", bus.rd_data); end
    n_vec++; if (bus.busy_cnt !== 6'd1) begin n_err++; $display("FAIL r0_cnt: got %0d want 1", bus.busy_cnt); end
    n_vec++; if (bus.rd_busy !== 3'b000) begin n_err++; $display("FAIL r0_rdbusy: got %0b want 0", bus.rd_busy); end
    we[1] = 1; wa[1] = 6; wd[1] = 32'h66; apply(); tick();
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
`ifdef GRF_MP_BYPASS_EN
    want = 32'hB;
`else
    want = 32'hA;
`endif
    idle(); we[0] = 1; wa[0] = 9; wd[0] = 32'hA; apply(); tick();
    idle(); we[1] = 1; wa[1] = 9; wd[1] = 32'hB; rd_a[2] = 9; apply(); #1;
    n_vec++; if (bus.rd_data[2*W +: W] !== want) begin n_err++; $display("FAIL bypass_same: got %0h want %0h", bus.rd_data[2*W +: W], want); end
    tick();
    idle(); rd_a[2] = 9; apply(); #1;
    n_vec++; if (bus.rd_data[2*W +: W] !== 32'hB) begin n_err++; $display("FAIL bypass_next: got %0h want b", bus.rd_data[2*W +: W]); end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NRD; i++) rd_a[i] = rand_addr();
      for (int j = 0; j < NWR; j++) begin
        we[j] = ($urandom_range(0, 9) < 4);
        wa[j] = rand_addr();
        wd[j] = $urandom;
      end
      ie = ($urandom_range(0, 1) == 1);
      ia = rand_addr();
      apply(); #1;
      for (int i = 0; i < NRD; i++) exp_q.push_back(m_rd(i));
      for (int i = 0; i < NRD; i++) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.rd_data[i*W +: W] !== e) begin
          n_err++; $display("FAIL rnd_rd_data[%0d] cyc %0d: got %0h want %0h", i, c, bus.rd_data[i*W +: W], e);
        end
        n_vec++;
        if (bus.rd_busy[i] !== m_rd_busy(i)) begin
          n_err++; $display("FAIL rnd_rd_busy[%0d] cyc %0d: got %0b want %0b", i, c, bus.rd_busy[i], m_rd_busy(i));
        end
      end
      n_vec++;
      if (bus.iss_ready !== m_ready()) begin
        n_err++; $display("FAIL rnd_iss_ready cyc %0d: got %0b want %0b", c, bus.iss_ready, m_ready());
      end
      n_vec++;
      if (bus.busy_cnt !== m_cnt()) begin
        n_err++; $display("FAIL rnd_busy_cnt cyc %0d: got %0d want %0d", c, bus.busy_cnt, m_cnt());
      end
      tick();
    end
    rst = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_dual_write();
    test_scoreboard();
    test_issue_writeback();
    test_r0();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_grf_mp
